// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the writable instruction memory
//
// Accepts a frame [N] [4*N data bytes, MSB first] [C] over a valid/ready
// handshake, where C is the XOR of N and every data byte. Each assembled
// 32-bit word produces a one-cycle write strobe into the instruction memory.
// The processor is held in reset (cpu_hold) until a load ends with a good
// checksum.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   start     one-cycle pulse that opens a load session (ignored while busy)
//   in_valid  byte-source valid
//   in_data   byte-source data
//   in_ready  loader accepts a byte this cycle (registered)
//   mem_we    one-cycle instruction-memory write strobe
//   mem_addr  word address of the write
//   mem_wd    write data
//   cpu_hold  processor reset/hold request
//   busy      session in progress
//   done      sticky: last session succeeded
//   err       sticky: last session failed (bad count or bad checksum)

module imem_loader #(
  parameter int DEPTH         = 64,
  parameter int AW            = 6,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    FIN
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [7:0]    csum;
  logic [7:0]    nwords;
  logic [AW-1:0] widx;
  logic [1:0]    bidx;
  logic [23:0]   shreg;   // first three bytes of the word being assembled

  logic          accept;
  logic          count_big;
  logic          last_byte;
  logic          last_word;
  logic [8:0]    widx_p1;

  assign accept    = in_valid && in_ready;
  assign count_big = 32'(in_data) > 32'(DEPTH);
  assign last_byte = (bidx == 2'd3);
  assign widx_p1   = 9'(widx) + 9'd1;
  // Compared in 9 bits so a full DEPTH-word frame ends cleanly on the last index.
  assign last_word = (widx_p1 == {1'b0, nwords});

  always_comb begin
    state_next = state;
    case (state)
      IDLE, FIN: begin
        if (start) state_next = COUNT;
      end
      COUNT: begin
        if (accept) begin
          if (in_data == 8'd0) state_next = CHECK;
          else if (count_big)  state_next = FIN;
          else                 state_next = DATA;
        end
      end
      DATA: begin
        if (accept && last_byte && last_word) state_next = CHECK;
      end
      CHECK: begin
        if (accept) state_next = FIN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= HOLD_AT_RESET;
      csum     <= 8'd0;
      nwords   <= 8'd0;
      widx     <= '0;
      bidx     <= 2'd0;
      shreg    <= 24'd0;
    end else begin
      state    <= state_next;
      // Ready follows the state being entered, so it is high exactly in
      // COUNT, DATA and CHECK.
      in_ready <= (state_next == COUNT) || (state_next == DATA) ||
                  (state_next == CHECK);
      mem_we   <= 1'b0;

      case (state)
        IDLE, FIN: begin
          if (start) begin
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
            csum     <= 8'd0;
            widx     <= '0;
            bidx     <= 2'd0;
          end
        end
        COUNT: begin
          if (accept) begin
            csum   <= csum ^ in_data;
            nwords <= in_data;
            if (in_data != 8'd0 && count_big) begin
              err  <= 1'b1;
              busy <= 1'b0;
            end
          end
        end
        DATA: begin
          if (accept) begin
            shreg <= {shreg[15:0], in_data};
            csum  <= csum ^ in_data;
            if (last_byte) begin
              mem_we   <= 1'b1;
              mem_addr <= widx;
              mem_wd   <= {shreg, in_data};
              widx     <= widx + AW'(1);
              bidx     <= 2'd0;
            end else begin
              bidx <= bidx + 2'd1;
            end
          end
        end
        CHECK: begin
          if (accept) begin
            busy <= 1'b0;
            if (in_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH(64), .AW(6), .HOLD_AT_RESET(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          c;
  } wr_t;

  wr_t wr_q[$];
  wr_t exp_q[$];
  int  acc_cyc[$];

  always @(negedge clk) begin
    if (mem_we) wr_q.push_back('{mem_addr, mem_wd, cyc});
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wd",   mem_wd,        32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy",     32'(busy),     32'd1);
    chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("start_done",     32'(done),     32'd0);
    chk("start_err",      32'(err),      32'd0);
  endtask

  // Presents the bytes of f in order; optional random valid gaps; optional
  // start pulse when byte index sidx is being offered.
  task automatic send(input logic [7:0] f[$], input bit gaps, input int sidx);
    int i = 0;
    int guard = 0;
    bit sdone = 1'b0;
    acc_cyc.delete();
    while (i < f.size() && guard < 5000) begin
      @(negedge clk);
      start = 1'b0;
      if (i == sidx && !sdone) begin
        start = 1'b1;
        sdone = 1'b1;
      end
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = f[i];
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        i++;
      end
      guard++;
    end
    if (i < f.size()) chk("send_timeout", 32'(i), 32'(f.size()));
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Reference: the expected writes and outcome follow directly from the frame.
  task automatic model(input logic [7:0] f[$], output bit d, output bit e);
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = int'(f[0]);
    if (n > 64) begin
      d = 1'b0;
      e = 1'b1;
      return;
    end
    x = 8'd0;
    for (int k = 0; k <= 4 * n; k++) x ^= f[k];
    for (int w = 0; w < n; w++)
      exp_q.push_back('{6'(w), {f[1+4*w], f[2+4*w], f[3+4*w], f[4+4*w]}, 0});
    d = (f[4*n+1] == x);
    e = !d;
  endtask

  function automatic void build(input int n, input bit badc, output logic [7:0] f[$]);
    logic [7:0] x;
    logic [7:0] b;
    f.delete();
    f.push_back(8'(n));
    if (n > 64) return;
    x = 8'(n);
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom);
      f.push_back(b);
      x ^= b;
    end
    f.push_back(badc ? (x ^ 8'h01) : x);
  endfunction

  task automatic run_frame(input logic [7:0] f[$], input bit gaps, input int sidx,
                           output bit d, output bit e);
    int w = 0;
    wr_q.delete();
    pulse_start();
    send(f, gaps, sidx);
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("busy_clear", 32'(busy), 32'd0);
    model(f, d, e);
    chk("done",     32'(done),     32'(d));
    chk("err",      32'(err),      32'(e));
    chk("cpu_hold", 32'(cpu_hold), 32'(!d));
    chk("in_ready_end", 32'(in_ready), 32'd0);
    chk("nwrites", 32'(wr_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      chk("wr_addr", 32'(wr_q[k].addr), 32'(exp_q[k].addr));
      chk("wr_data", wr_q[k].data, exp_q[k].data);
    end
  endtask

  typedef struct {
    int n;
    bit badc;
    bit gaps;
    int sidx;
    bit ed;
    bit ee;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] f[$];
    logic [7:0] spec_f[12];
    bit d;
    bit e;
    int nw;

    vecs[0] = '{2,  1'b0, 1'b0, -1, 1'b1, 1'b0};
    vecs[1] = '{2,  1'b1, 1'b0, -1, 1'b0, 1'b1};
    vecs[2] = '{65, 1'b0, 1'b0, -1, 1'b0, 1'b1};
    vecs[3] = '{0,  1'b0, 1'b0, -1, 1'b1, 1'b0};
    vecs[4] = '{64, 1'b0, 1'b0, -1, 1'b1, 1'b0};
    vecs[5] = '{2,  1'b0, 1'b1, -1, 1'b1, 1'b0};
    vecs[6] = '{3,  1'b0, 1'b1,  5, 1'b1, 1'b0};
    vecs[7] = '{5,  1'b1, 1'b1, -1, 1'b0, 1'b1};
    vecs[8] = '{0,  1'b1, 1'b0, -1, 1'b0, 1'b1};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;

    // Spec example frame with valid held high: exact data and write timing.
    spec_f = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02,
               8'h00, 8'h00};
    f.delete();
    for (int k = 0; k < 10; k++) f.push_back(spec_f[k]);
    run_frame(f, 1'b0, -1, d, e);
    chk("spec_done", 32'(done), 32'd1);
    chk("spec_hold", 32'(cpu_hold), 32'd0);
    if (wr_q.size() == 2 && acc_cyc.size() == 10) begin
      chk("spec_w0", wr_q[0].data, 32'h12345678);
      chk("spec_w1", wr_q[1].data, 32'h9ABCDEF0);
      chk("spec_t0", 32'(wr_q[0].c), 32'(acc_cyc[4] + 1));
      chk("spec_t1", 32'(wr_q[1].c), 32'(acc_cyc[8] + 1));
    end else begin
      chk("spec_shape", 32'(wr_q.size()), 32'd2);
    end

    // Bytes offered in FIN are ignored.
    nw = wr_q.size();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      chk("fin_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("fin_nowrite", 32'(wr_q.size()), 32'(nw));
    chk("fin_done", 32'(done), 32'd1);

    // Table vectors.
    foreach (vecs[v]) begin
      build(vecs[v].n, vecs[v].badc, f);
      run_frame(f, vecs[v].gaps, vecs[v].sidx, d, e);
      chk("vec_done", 32'(done), 32'(vecs[v].ed));
      chk("vec_err",  32'(err),  32'(vecs[v].ee));
      if (!vecs[v].gaps && wr_q.size() > 1)
        for (int k = 1; k < wr_q.size(); k++)
          chk("stream_gap", 32'(wr_q[k].c - wr_q[k-1].c), 32'd4);
    end

    // Random frames against the model.
    for (int r = 0; r < 6; r++) begin
      build(int'($urandom_range(0, 70)), 1'($urandom_range(0, 1)), f);
      run_frame(f, 1'($urandom_range(0, 1)), -1, d, e);
    end

    // Reset after 6 data bytes: one write issued, then everything returns to reset values.
    f.delete();
    for (int k = 0; k < 7; k++) f.push_back(spec_f[k]);
    wr_q.delete();
    pulse_start();
    send(f, 1'b0, -1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_nwrites", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() >= 1) chk("abort_addr", 32'(wr_q[0].addr), 32'd0);
    f.delete();
    for (int k = 0; k < 10; k++) f.push_back(spec_f[k]);
    run_frame(f, 1'b0, -1, d, e);
    chk("after_abort_done", 32'(done), 32'd1);

    // Simultaneous start and reset: reset wins.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_hold", 32'(cpu_hold), 32'd1);
    chk("rst_start_ready", 32'(in_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: the write side of the 64-word instruction memory.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Issues one write strobe per word into the writable instruction-memory port.
- Holds the processor in reset (cpu_hold) until a load completes with a good checksum.

Parameters:
- DEPTH, 64, number of instruction words in memory; a frame word count above DEPTH is an error.
- AW, 6, word-address width; 2**AW >= DEPTH.
- HOLD_AT_RESET, 1, reset value of cpu_hold (1: CPU held until the first good load; 0: CPU runs the preloaded image).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load session. Ignored while busy.
- in_valid  in  1  byte-source valid.
- in_data  in  8  byte-source data.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  one-cycle instruction-memory write strobe.
- mem_addr  out  AW  word address of the write.
- mem_wd  out  32  write data.
- cpu_hold  out  1  processor reset/hold request.
- busy  out  1  session in progress.
- done  out  1  sticky: last session succeeded.
- err  out  1  sticky: last session failed (bad count or bad checksum).

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high.
- Reset values:
  - state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wd=0.
  - busy=0, done=0, err=0, cpu_hold=HOLD_AT_RESET.
  - word index, byte index, checksum all 0.
- Handshake:
  - A byte transfers on a rising edge with in_valid&&in_ready.
  - in_ready is registered: high exactly in COUNT, DATA, CHECK; low elsewhere.
  - in_valid without in_ready has no effect; the source holds its data.
- Frame format: [N] [4*N data bytes, MSB first] [C], where C = XOR of N and every data byte.
- States and transitions:
  - IDLE/FIN (FIN = ended session):
    - start -> COUNT.
    - Same edge: done=0, err=0, cpu_hold=1, busy=1, checksum=0, word index=0, byte index=0.
  - COUNT, on byte accept:
    - checksum ^= byte.
    - N=0 -> CHECK.
    - N>DEPTH -> FIN with err=1, busy=0, cpu_hold stays 1, no writes.
    - Otherwise latch N and go to DATA.
  - DATA, on byte accept:
    - Shift the byte into the word assembly register (first byte -> bits 31:24); checksum ^= byte; byte index++.
    - On the 4th byte: next cycle mem_we=1, mem_addr=word index, mem_wd=assembled word; then word index++ and byte index=0.
    - After word N-1's 4th byte -> CHECK.
  - CHECK, on byte accept:
    - Byte == checksum -> FIN with done=1, cpu_hold=0.
    - Else FIN with err=1, cpu_hold=1.
    - busy=0 in both cases.
- Write timing:
  - mem_we is high for exactly one cycle per word, one cycle after the 4th byte's accept edge.
  - mem_addr/mem_wd are stable while mem_we=1.
  - Back-to-back bytes (in_valid held high) sustain 1 byte/cycle. The next word's first byte may be accepted in the same cycle mem_we is high.
- Words at addresses >= N are untouched. Writes already issued before a checksum failure are not undone.
- start while busy: ignored; the session continues unaffected.
- reset mid-session: aborts immediately to the reset values. No further mem_we; a partial word is discarded.
- Simultaneous start and reset: reset wins.
- done and err are never both 1.

Test Plan:
- Good 2-word load: reset, start, bytes 02, 12 34 56 78, 9A BC DE F0, C=0x02^...=0x02 -> mem_we pulses twice: (addr 0, 0x12345678) and (addr 1, 0x9ABCDEF0), each one cycle after the 4th byte; done=1, err=0, cpu_hold=0, busy=0.
- Bad checksum: same frame with C=0x03 -> both writes still occur; err=1, done=0, cpu_hold=1.
- Count bounds:
  - N=0x41 (65) with DEPTH=64 -> immediate err=1, no mem_we, in_ready=0 afterwards.
  - N=0 then C=0x00 -> done=1, no writes.
  - N=0x40 with all 256 data bytes streamed, in_valid held high -> 64 writes at addrs 0..63, no gaps beyond 1 byte/cycle, last addr 63.
- Backpressure and gaps: in_valid toggled randomly during the good 2-word frame -> identical writes and done; bytes presented while in_ready=0 (IDLE/FIN) are ignored.
- Reset mid-session: assert reset after 6 data bytes of a 2-word frame -> exactly one write (addr 0) issued before reset; all outputs at reset values next cycle; a fresh start plus the good frame then succeeds.
- Start during a session: pulse start during DATA -> no effect; frame completes normally. Start after err=1 -> err clears on the same edge, cpu_hold=1, busy=1.
